// File: rtl/trng_bit_collector_if.sv
// Signal bundle between the TRNG / consumer side and trng_bit_collector.
//
// Handshake semantics:
//   TRNG side is four-phase. The TRNG raises RAW_READY with RAW_BIT stable.
//   The collector answers RAW_ACK=1. The TRNG then drops RAW_READY, and the
//   collector drops RAW_ACK. Exactly one raw bit is taken per RAW_READY pulse.
//   Consumer side: WORD_VALID stays high with WORD stable until WORD_ACK is
//   sampled high, or until START begins a new word. WORD_ACK while
//   WORD_VALID=0 has no effect.
interface trng_bit_collector_if #(
   parameter int WIDTH = 16
);
   logic             START;
   logic             TRNG_EN;
   logic             RAW_BIT;
   logic             RAW_READY;
   logic             RAW_ACK;
   logic [WIDTH-1:0] WORD;
   logic             WORD_VALID;
   logic             WORD_ACK;
   logic             HEALTH_FAIL;
   logic [2:0]       state;   // debug view of the collector FSM state

   // Driver side: TRNG model plus consumer
   modport master (
      output START, RAW_BIT, RAW_READY, WORD_ACK,
      input  TRNG_EN, RAW_ACK, WORD, WORD_VALID, HEALTH_FAIL, state
   );

   // Collector side
   modport slave (
      input  START, RAW_BIT, RAW_READY, WORD_ACK,
      output TRNG_EN, RAW_ACK, WORD, WORD_VALID, HEALTH_FAIL, state
   );
endinterface

// File: rtl/trng_bit_collector.sv
// Collects raw ring-oscillator TRNG bits over a four-phase handshake.
// It synchronizes them into CLK, von Neumann debiases them, and runs a
// repetition-count health test. Debiased bits are packed LSB-first into a
// WIDTH-bit word, which is handed to the consumer with valid/ack.
module trng_bit_collector #(
   parameter int WIDTH     = 16,
   parameter int REP_LIMIT = 8
) (
   input logic                  CLK,
   input logic                  RST,
   trng_bit_collector_if.slave  bus
);

   localparam int IW = $clog2(WIDTH + 1);
   localparam int RW = $clog2(REP_LIMIT + 1);
   localparam logic [IW-1:0] IDX_FULL = IW'(WIDTH);
   localparam logic [RW-1:0] RUN_TRIP = RW'(REP_LIMIT);
   localparam logic [RW-1:0] RUN_ONE  = RW'(1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COLLECT   = 3'd1,
      WAIT_DROP = 3'd2,
      DONE      = 3'd3,
      FAIL      = 3'd4
   } state_t;

   state_t           state;
   state_t           state_next;

   // Synchronizer flops for the asynchronous TRNG inputs
   logic             ready_meta;
   logic             rdy_s;
   logic             bit_meta;
   logic             bit_s;

   // Word assembly and health-test state
   logic [WIDTH-1:0] word;
   logic [IW-1:0]    idx;
   logic             pair_full;
   logic             pair_bit;
   logic [RW-1:0]    run_cnt;
   logic [RW-1:0]    run_next;
   logic             prev_bit;
   logic             health_fail;

   // Control strobes from the FSM to the datapath
   logic             start_clear;
   logic             capture;
   logic             emit;

   // Two-flop synchronizers for RAW_READY and RAW_BIT; reset clears both
   always_ff @(posedge CLK) begin
      if (RST) begin
         ready_meta <= 1'b0;
         rdy_s      <= 1'b0;
         bit_meta   <= 1'b0;
         bit_s      <= 1'b0;
      end else begin
         ready_meta <= bus.RAW_READY;
         rdy_s      <= ready_meta;
         bit_meta   <= bus.RAW_BIT;
         bit_s      <= bit_meta;
      end
   end

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic and datapath strobes
   always_comb begin
      state_next  = state;
      start_clear = 1'b0;
      capture     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.START) begin
               start_clear = 1'b1;
               state_next  = COLLECT;
            end
         end
         COLLECT: begin
            // START is deliberately ignored while a word is in progress
            if (rdy_s) begin
               capture    = 1'b1;
               state_next = WAIT_DROP;
            end
         end
         WAIT_DROP: begin
            // Health trip outranks word completion on the same raw bit
            if (!rdy_s) begin
               if (health_fail) begin
                  state_next = FAIL;
               end else if (idx == IDX_FULL) begin
                  state_next = DONE;
               end else begin
                  state_next = COLLECT;
               end
            end
         end
         DONE: begin
            // A fresh START wins over a simultaneous WORD_ACK
            if (bus.START) begin
               start_clear = 1'b1;
               state_next  = COLLECT;
            end else if (bus.WORD_ACK) begin
               state_next = IDLE;
            end
         end
         FAIL: begin
            if (bus.START) begin
               start_clear = 1'b1;
               state_next  = COLLECT;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Run-length update and debiaser emit decision for the bit being captured
   always_comb begin
      run_next = RUN_ONE;
      if ((run_cnt != '0) && (bit_s == prev_bit)) begin
         run_next = (run_cnt == RUN_TRIP) ? run_cnt : run_cnt + 1'b1;
      end
      emit = pair_full && (pair_bit != bit_s) && (idx != IDX_FULL);
   end

   // Datapath: clear on START, otherwise process one raw bit per capture
   always_ff @(posedge CLK) begin
      if (RST) begin
         word        <= '0;
         idx         <= '0;
         pair_full   <= 1'b0;
         pair_bit    <= 1'b0;
         run_cnt     <= '0;
         prev_bit    <= 1'b0;
         health_fail <= 1'b0;
      end else if (start_clear) begin
         word        <= '0;
         idx         <= '0;
         pair_full   <= 1'b0;
         pair_bit    <= 1'b0;
         run_cnt     <= '0;
         prev_bit    <= 1'b0;
         health_fail <= 1'b0;
      end else if (capture) begin
         // run_cnt==0 means no previous raw bit since the last clear
         run_cnt  <= run_next;
         prev_bit <= bit_s;
         if (run_next == RUN_TRIP) begin
            health_fail <= 1'b1;
         end
         if (!pair_full) begin
            pair_full <= 1'b1;
            pair_bit  <= bit_s;
         end else begin
            // 01 emits 0 and 10 emits 1, so the emitted bit is the pair's first bit
            pair_full <= 1'b0;
            if (emit) begin
               word <= word | ({{(WIDTH-1){1'b0}}, pair_bit} << idx);
               idx  <= idx + 1'b1;
            end
         end
      end
   end

   // Outputs decode directly from registered state
   assign bus.TRNG_EN     = (state == COLLECT) || (state == WAIT_DROP);
   assign bus.RAW_ACK     = (state == WAIT_DROP);
   assign bus.WORD_VALID  = (state == DONE);
   assign bus.WORD        = word;
   assign bus.HEALTH_FAIL = health_fail;
   assign bus.state       = state;

endmodule

// File: tb/tb_trng_bit_collector.sv
// Self-checking bench for trng_bit_collector: directed test-plan scenarios
// plus randomized raw streams compared against a list-based reference model.
module tb_trng_bit_collector;

   localparam int WIDTH     = 16;
   localparam int REP_LIMIT = 8;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_DONE    = 3'd3;
   localparam logic [2:0] S_FAIL    = 3'd4;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   trng_bit_collector_if #(.WIDTH(WIDTH)) bus ();

   trng_bit_collector #(
      .WIDTH     (WIDTH),
      .REP_LIMIT (REP_LIMIT)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // Clock
   always #5 CLK = ~CLK;

   // Scoreboard state
   int               n_checks = 0;
   int               n_errors = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic             raw_q[$];
   logic [WIDTH-1:0] m_word;
   int               m_used;
   logic             m_fail;
   logic [WIDTH-1:0] last_word;
   logic             mon_on = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // WORD_VALID and TRNG_EN must never be high together
   always @(negedge CLK) begin
      if (mon_on) check("valid_en_excl", {31'd0, bus.WORD_VALID & bus.TRNG_EN}, 32'd0);
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: walks the raw list applying the rules directly
   task automatic model_run();
      int run;
      int dcnt;
      m_word = '0;
      m_used = raw_q.size();
      m_fail = 1'b0;
      run    = 0;
      dcnt   = 0;
      for (int i = 0; i < raw_q.size(); i++) begin
         run = (i > 0 && raw_q[i] == raw_q[i-1]) ? run + 1 : 1;
         if ((i % 2 == 1) && (raw_q[i-1] != raw_q[i])) begin
            m_word[dcnt] = raw_q[i-1];
            dcnt++;
         end
         if (run >= REP_LIMIT) begin
            m_fail = 1'b1;
            m_used = i + 1;
            break;
         end
         if (dcnt == WIDTH) begin
            m_used = i + 1;
            break;
         end
      end
   endtask

   // Raw stream generators: 0 random biased, 1 "10,01", 2 "00,11,10",
   // 3 eight ones, 4 five non-repeating pairs plus one extra bit
   task automatic gen_stream(input int mode);
      int thr;
      logic b;
      raw_q.delete();
      case (mode)
         1: repeat (8) begin raw_q.push_back(1); raw_q.push_back(0); raw_q.push_back(0); raw_q.push_back(1); end
         2: repeat (16) begin
               raw_q.push_back(0); raw_q.push_back(0); raw_q.push_back(1);
               raw_q.push_back(1); raw_q.push_back(1); raw_q.push_back(0);
            end
         3: repeat (REP_LIMIT) raw_q.push_back(1);
         4: begin
               repeat (5) begin
                  b = 1'($urandom_range(0, 1));
                  raw_q.push_back(b);
                  raw_q.push_back(~b);
               end
               raw_q.push_back(1'($urandom_range(0, 1)));
            end
         default: begin
               thr = $urandom_range(35, 65);
               repeat (200) raw_q.push_back($urandom_range(0, 99) < thr);
            end
      endcase
   endtask

   // Driver: one four-phase raw-bit transfer with random gaps
   task automatic send_bit(input logic b);
      int n;
      bus.RAW_BIT = b;
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      bus.RAW_READY = 1'b1;
      n = 0;
      while (bus.RAW_ACK !== 1'b1 && n < 12) begin @(negedge CLK); n++; end
      check("ack_rise", {31'd0, bus.RAW_ACK}, 32'd1);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      bus.RAW_READY = 1'b0;
      n = 0;
      while (bus.RAW_ACK !== 1'b0 && n < 12) begin @(negedge CLK); n++; end
      check("ack_fall", {31'd0, bus.RAW_ACK}, 32'd0);
      bus.RAW_BIT = 1'($urandom_range(0, 1));
   endtask

   // Driver: RAW_READY held for 20 cycles with cycle-exact RAW_ACK checks
   task automatic send_bit_timed(input logic b);
      bus.RAW_BIT   = b;
      bus.RAW_READY = 1'b1;
      for (int t = 1; t <= 23; t++) begin
         @(negedge CLK);
         check($sformatf("ack_timing_t%0d", t), {31'd0, bus.RAW_ACK}, {31'd0, (t >= 3 && t <= 22)});
         if (t == 20) bus.RAW_READY = 1'b0;
      end
   endtask

   task automatic pulse_start();
      bus.START = 1'b1;
      @(negedge CLK);
      bus.START = 1'b0;
      check("start_en", {31'd0, bus.TRNG_EN}, 32'd1);
      check("start_word", {16'd0, bus.WORD}, 32'd0);
      check("start_hf", {31'd0, bus.HEALTH_FAIL}, 32'd0);
      check("start_valid", {31'd0, bus.WORD_VALID}, 32'd0);
   endtask

   // Feeds the current stream exactly as far as the model says it is consumed
   task automatic feed(input logic timed_first);
      model_run();
      exp_q.push_back(m_word);
      for (int i = 0; i < m_used; i++) begin
         if (i == 0 && timed_first) send_bit_timed(raw_q[0]);
         else                       send_bit(raw_q[i]);
      end
      last_word = exp_q.pop_front();
      check("word", {16'd0, bus.WORD}, {16'd0, last_word});
      check("end_valid", {31'd0, bus.WORD_VALID}, {31'd0, ~m_fail});
      check("end_hf", {31'd0, bus.HEALTH_FAIL}, {31'd0, m_fail});
      check("end_en", {31'd0, bus.TRNG_EN}, 32'd0);
      check("end_state", {29'd0, bus.state}, {29'd0, (m_fail ? S_FAIL : S_DONE)});
   endtask

   task automatic consume();
      bus.WORD_ACK = 1'b1;
      @(negedge CLK);
      bus.WORD_ACK = 1'b0;
      check("ack_valid", {31'd0, bus.WORD_VALID}, 32'd0);
      check("ack_word_kept", {16'd0, bus.WORD}, {16'd0, last_word});
      check("ack_state", {29'd0, bus.state}, {29'd0, S_IDLE});
      check("ack_en", {31'd0, bus.TRNG_EN}, 32'd0);
   endtask

   initial begin
      bus.START     = 1'b0;
      bus.RAW_BIT   = 1'b0;
      bus.RAW_READY = 1'b0;
      bus.WORD_ACK  = 1'b0;
      last_word     = '0;

      // Reset
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      check("rst_word", {16'd0, bus.WORD}, 32'd0);
      check("rst_valid", {31'd0, bus.WORD_VALID}, 32'd0);
      check("rst_ack", {31'd0, bus.RAW_ACK}, 32'd0);
      check("rst_en", {31'd0, bus.TRNG_EN}, 32'd0);
      check("rst_hf", {31'd0, bus.HEALTH_FAIL}, 32'd0);
      check("rst_state", {29'd0, bus.state}, {29'd0, S_IDLE});
      mon_on = 1'b1;

      // Pattern 10,01 then consume
      pulse_start();
      gen_stream(1);
      feed(1'b0);
      check("pattern_5555", {16'd0, bus.WORD}, 32'h5555);
      consume();

      // Pattern 00,11,10: only the 10 pairs count
      pulse_start();
      gen_stream(2);
      feed(1'b0);
      check("pattern_ffff", {16'd0, bus.WORD}, 32'hffff);

      // START together with WORD_ACK in DONE: START wins
      bus.START    = 1'b1;
      bus.WORD_ACK = 1'b1;
      @(negedge CLK);
      bus.START    = 1'b0;
      bus.WORD_ACK = 1'b0;
      check("sa_en", {31'd0, bus.TRNG_EN}, 32'd1);
      check("sa_word", {16'd0, bus.WORD}, 32'd0);
      check("sa_valid", {31'd0, bus.WORD_VALID}, 32'd0);
      check("sa_state", {29'd0, bus.state}, {29'd0, S_COLLECT});

      // First bit with RAW_READY held for 20 cycles
      gen_stream(0);
      feed(1'b1);

      // Eight consecutive ones trip the health test
      pulse_start();
      gen_stream(3);
      feed(1'b0);
      check("hf_state", {29'd0, bus.state}, {29'd0, S_FAIL});
      pulse_start();
      gen_stream(0);
      feed(1'b0);

      // Reset after five debiased bits with RAW_ACK high
      pulse_start();
      gen_stream(4);
      model_run();
      for (int i = 0; i < 10; i++) send_bit(raw_q[i]);
      bus.RAW_BIT   = raw_q[10];
      bus.RAW_READY = 1'b1;
      for (int n = 0; n < 12 && bus.RAW_ACK !== 1'b1; n++) @(negedge CLK);
      check("pre_rst_ack", {31'd0, bus.RAW_ACK}, 32'd1);
      check("pre_rst_word", {16'd0, bus.WORD}, {16'd0, m_word});
      RST           = 1'b1;
      bus.RAW_READY = 1'b0;
      @(negedge CLK);
      check("mid_rst_word", {16'd0, bus.WORD}, 32'd0);
      check("mid_rst_valid", {31'd0, bus.WORD_VALID}, 32'd0);
      check("mid_rst_ack", {31'd0, bus.RAW_ACK}, 32'd0);
      check("mid_rst_en", {31'd0, bus.TRNG_EN}, 32'd0);
      check("mid_rst_hf", {31'd0, bus.HEALTH_FAIL}, 32'd0);
      check("mid_rst_state", {29'd0, bus.state}, {29'd0, S_IDLE});
      RST = 1'b0;
      @(negedge CLK);
      pulse_start();
      gen_stream(0);
      feed(1'b0);

      // Randomized words
      repeat (6) begin
         pulse_start();
         gen_stream(0);
         feed(1'b0);
         if (!m_fail && $urandom_range(0, 1) == 1) consume();
      end

      repeat (2) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
